// File: rtl/alu_backend_responder_if.sv
// Start/busy/done backend bus between the routing front-end (master) and a responder (slave).
interface alu_backend_responder_if;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  q_level;
  logic        overflow;

  modport master (output start, opcode, a, b,
                  input  busy, done, result, q_level, overflow);
  modport slave  (input  start, opcode, a, b,
                  output busy, done, result, q_level, overflow);
endinterface

// File: rtl/alu_backend_responder.sv
// Queued ALU responder with per-opcode-class latency on the start/busy/done protocol.
// Optional done/stall performance counters are enabled by defining ALU_RESP_PERF_CNT_EN.
`ifndef OP_BIN_MUL
`define OP_BIN_MUL 4'd2
`endif
`ifndef OP_DEC_MUL10
`define OP_DEC_MUL10 4'd6
`endif

module alu_backend_responder #(
  parameter int LAT_BIN = 1,
  parameter int LAT_DEC = 8,
  parameter int LAT_DUO = 6,
  parameter int QDEPTH  = 2
) (
  input  logic clk,
  input  logic rst,
  alu_backend_responder_if.slave bus
`ifdef ALU_RESP_PERF_CNT_EN
  ,
  output logic [15:0] done_count,
  output logic [15:0] stall_count
`endif
);

  // A zero latency would never produce a done, so it is promoted to one cycle.
  localparam logic [15:0] L_BIN = (LAT_BIN < 1) ? 16'd1 : 16'(LAT_BIN);
  localparam logic [15:0] L_DEC = (LAT_DEC < 1) ? 16'd1 : 16'(LAT_DEC);
  localparam logic [15:0] L_DUO = (LAT_DUO < 1) ? 16'd1 : 16'(LAT_DUO);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [31:0] job_res;
  logic [31:0] last_res;
  logic        overflow_q;

  logic [35:0] fifo_mem [8];
  logic [2:0]  rd_ptr, wr_ptr;
  logic [3:0]  count;

  logic        job_done, q_empty, q_full;
  logic        accept_direct, pop, push, drop, load;
  logic [35:0] head;
  logic [3:0]  load_op;
  logic [15:0] load_a, load_b;

  function automatic logic [15:0] job_latency(input logic [3:0] op);
    if (op <= `OP_BIN_MUL)        return L_BIN;
    else if (op <= `OP_DEC_MUL10) return L_DEC;
    else                          return L_DUO;
  endfunction

  function automatic logic [31:0] alu_eval(input logic [3:0] op, input logic [15:0] x,
                                           input logic [15:0] y);
    case (op[1:0])
      2'd0:    return {16'h0, x} + {16'h0, y};
      2'd1:    return {16'h0, x} - {16'h0, y};
      2'd2:    return {16'h0, x} * {16'h0, y};
      default: return {x, y};
    endcase
  endfunction

  function automatic logic [2:0] ptr_next(input logic [2:0] p);
    return (p == 3'(QDEPTH - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  assign job_done = (state == RUN) && (cnt == 16'd1);
  assign q_empty  = (count == 4'd0);
  assign q_full   = (count == 4'(QDEPTH));
  assign head     = fifo_mem[rd_ptr];

  // In the done cycle the queue head has priority; a fresh start only goes direct when nothing waits.
  assign pop           = job_done && !q_empty;
  assign accept_direct = bus.start && ((state == IDLE) || (job_done && q_empty));
  assign push          = bus.start && (state == RUN) && !(job_done && q_empty) && (!q_full || pop);
  assign drop          = bus.start && (state == RUN) && !(job_done && q_empty) && q_full && !pop;
  assign load          = pop || accept_direct;
  assign load_op       = pop ? head[35:32] : bus.opcode;
  assign load_a        = pop ? head[31:16] : bus.a;
  assign load_b        = pop ? head[15:0]  : bus.b;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (job_done && !load) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state == RUN);
    bus.done     = job_done;
    bus.result   = job_done ? job_res : last_res;
    bus.q_level  = count;
    bus.overflow = overflow_q;
  end

  // The result is computed at acceptance so later operand changes cannot disturb the job.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 16'd0;
      job_res    <= 32'd0;
      last_res   <= 32'd0;
      rd_ptr     <= 3'd0;
      wr_ptr     <= 3'd0;
      count      <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      if (load) begin
        cnt     <= job_latency(load_op);
        job_res <= alu_eval(load_op, load_a, load_b);
      end else if (state == RUN) begin
        cnt <= cnt - 16'd1;
      end
      if (job_done) last_res <= job_res;
      if (push)     wr_ptr   <= ptr_next(wr_ptr);
      if (pop)      rd_ptr   <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.opcode, bus.a, bus.b};
  end

`ifdef ALU_RESP_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      done_count  <= 16'd0;
      stall_count <= 16'd0;
    end else begin
      if (job_done && (done_count != 16'hFFFF))    done_count  <= done_count + 16'd1;
      if (!q_empty && (stall_count != 16'hFFFF))   stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_backend_responder.md
Name: alu_backend_responder

Overview:
Responder end of the start/busy/done backend protocol driven by the routing front-end. Accepts single-cycle start pulses carrying an opcode and two 16-bit operands, and queues requests that arrive while a job is running. Each job runs for a per-opcode-class latency, then returns a 32-bit result with a one-cycle done pulse. It is a drop-in backend for router integration and latency-tuning experiments.

Parameters:
LAT_BIN, 1, cycles for binary-class opcodes (opcode <= `OP_BIN_MUL); 0 treated as 1
LAT_DEC, 8, cycles for decimal-class opcodes (`OP_BIN_MUL < opcode <= `OP_DEC_MUL10); 0 treated as 1
LAT_DUO, 6, cycles for duodecimal-class opcodes (opcode > `OP_DEC_MUL10); 0 treated as 1
QDEPTH, 2, pending-request FIFO depth (1..8)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  request strobe, sampled every cycle
opcode  in  4  operation code, `include "common_opcodes.vh"
a  in  16  operand A
b  in  16  operand B
busy  out  1  job in flight
done  out  1  one-cycle completion pulse
result  out  32  result, valid when done is high, held until the next done
q_level  out  4  number of pending queued requests
overflow  out  1  sticky: a start was dropped because the queue was full

Behaviour:
- Reset values: busy=0, done=0, result=0, q_level=0, overflow=0. The FSM goes to IDLE and the queue is emptied.
- Class is decoded from opcode using the thresholds above. The class selects the latency L and is latched with the job.
- Arithmetic uses opcode[1:0], independent of class:
  - 0: a+b, zero-extended to 32 bits
  - 1: a-b, 32-bit two's complement
  - 2: a*b, unsigned, 32 bits
  - 3: {a,b}
- Operands are captured at acceptance. Later changes on a/b/opcode do not affect the job.
- FSM states: IDLE and RUN.
  - IDLE: start in cycle c accepts the job and loads a down-counter with L. Next state RUN.
  - RUN: the counter decrements each cycle. busy is high in cycles c+1..c+L. done and result appear in cycle c+L.
- Latency: done is high exactly L cycles after the start cycle. With L=1, done is in cycle c+1.
- Start while RUN and not in the done cycle: the request is pushed to the FIFO. If the FIFO is full, the request is dropped and overflow is set.
- Done cycle, FIFO non-empty: the head is popped and accepted in the same cycle (acceptance cycle = the done cycle). Stay in RUN, busy stays high, next done at +L_next.
  - A simultaneous start is pushed.
  - Push and pop in the same cycle are both allowed even when the FIFO is full; q_level is unchanged.
- Done cycle, FIFO empty, start high: that start is accepted directly as the next job. Stay in RUN.
- Done cycle, FIFO empty, start low: go to IDLE. busy drops in the next cycle.
- Ordering: strictly FIFO. Results return in request order.
- overflow clears only on rst.
- Reset mid-operation: the in-flight job and all queued jobs are discarded, and no done is emitted. A start in the reset cycle is ignored.

Optional Feature:
ALU_RESP_PERF_CNT_EN.
- Defined: adds output port done_count [15:0], a saturating count of done pulses (sticks at 16'hFFFF), reset to 0. Also adds stall_count [15:0], a saturating count of cycles in which a request waits in the FIFO (q_level != 0), reset to 0.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Reset, then start with opcode=0, a=16'h0003, b=16'h0004 -> done exactly 1 cycle later, result=32'h00000007. busy high only in the done cycle; q_level=0.
- Start with opcode=4'hF (duodecimal class, [1:0]=3), a=16'hABCD, b=16'h1234 -> done 6 cycles later, result=32'hABCD1234. busy high for 6 cycles.
- Start with opcode=`OP_DEC_MUL10 in cycle c, then opcode=1 (binary sub), a=16'h0001, b=16'h0002 in cycle c+2:
  - q_level=1 in cycle c+3.
  - First done in cycle c+8; second done in cycle c+9 with result=32'hFFFFFFFF.
  - busy stays continuously high between the two.
- With QDEPTH=2, while running a duodecimal job, issue 3 extra starts -> first two queued (q_level=2), third dropped, overflow=1. Exactly 3 done pulses total.
- Start in the exact done cycle with an empty queue, opcode=2, a=16'h0100, b=16'h0100 -> accepted with no idle gap; next done L_BIN later with result=32'h00010000.
- Assert rst for 1 cycle mid-way through an 8-cycle decimal job with 1 queued request -> no done for 20 cycles; busy=0, q_level=0, overflow=0. A subsequent start completes normally.
